// File: rtl/adaptive_thresh_pkg.sv
// Shared definitions for the adaptive-thresholding pipeline: phase codes,
// divide-by-9 reciprocal constants and the box-filter FSM encoding.
package adaptive_thresh_pkg;

  localparam logic [2:0] GS_BOX    = 3'd1;
  localparam logic [2:0] GS_THRESH = 3'd2;

  localparam logic [12:0] RECIP9       = 13'd7282;
  localparam int          RECIP9_SHIFT = 16;

  localparam int ACC_W  = 12;
  localparam int PROD_W = 25;
  localparam int PIX_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LAST  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } box_state_e;

endpackage

// File: rtl/box_mean_div9.sv
// Combinational 3x3 mean: floor(acc/9) via multiply by 7282 and shift by 16,
// exact for every accumulator value a full 9-tap window of bytes can reach.
module box_mean_div9
  import adaptive_thresh_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  output logic [PIX_W-1:0] mean_o
);

  logic [PROD_W-1:0] prod;

  assign prod   = PROD_W'(acc_i) * PROD_W'(RECIP9);
  assign mean_o = PIX_W'(prod >> RECIP9_SHIFT);

endmodule

// File: rtl/box_filter.sv
// 3x3 clamp-to-edge box filter: walks the image in raster order, reads nine
// neighbours per pixel through a 1-cycle-latency port and writes their mean.
module box_filter
  import adaptive_thresh_pkg::*;
#(
  parameter int         WIDTH_BITS  = 8,
  parameter int         HEIGHT_BITS = 8,
  parameter logic [2:0] RUN_STATE   = GS_BOX
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             global_state,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [7:0]             iImageData,
  output logic [WIDTH_BITS-1:0]  oThresholdCol,
  output logic [HEIGHT_BITS-1:0] oThresholdRow,
  output logic [7:0]             oThresholdData,
  output logic                   oThresholdWren,
  output logic                   finished
);

  box_state_e state_q, state_d;

  logic [3:0]             tap_q, tap_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [WIDTH_BITS-1:0]  col_q, col_d;
  logic [HEIGHT_BITS-1:0] row_q, row_d;
  logic [WIDTH_BITS-1:0]  img_col_q, img_col_d;
  logic [HEIGHT_BITS-1:0] img_row_q, img_row_d;
  logic [WIDTH_BITS-1:0]  thr_col_q, thr_col_d;
  logic [HEIGHT_BITS-1:0] thr_row_q, thr_row_d;
  logic [PIX_W-1:0]       thr_data_q, thr_data_d;
  logic                   wren_q, wren_d;
  logic                   fin_q, fin_d;

  logic                   run;
  logic                   last_pix;
  logic [ACC_W-1:0]       acc_sum;
  logic [PIX_W-1:0]       mean;
  logic [WIDTH_BITS-1:0]  nxt_col;
  logic [HEIGHT_BITS-1:0] nxt_row;

  logic                   load_addr;
  logic [3:0]             addr_tap;
  logic [WIDTH_BITS-1:0]  addr_col;
  logic [HEIGHT_BITS-1:0] addr_row;
  logic [1:0]             dx_sel, dy_sel;

  assign run      = (global_state == RUN_STATE);
  assign last_pix = (col_q == '1) && (row_q == '1);
  assign acc_sum  = acc_q + ACC_W'(iImageData);
  assign nxt_col  = col_q + WIDTH_BITS'(1);
  assign nxt_row  = (col_q == '1) ? row_q + HEIGHT_BITS'(1) : row_q;

  box_mean_div9 u_div9 (
    .acc_i  (acc_sum),
    .mean_o (mean)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tap_q      <= '0;
      acc_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      img_col_q  <= '0;
      img_row_q  <= '0;
      thr_col_q  <= '0;
      thr_row_q  <= '0;
      thr_data_q <= '0;
      wren_q     <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      acc_q      <= acc_d;
      col_q      <= col_d;
      row_q      <= row_d;
      img_col_q  <= img_col_d;
      img_row_q  <= img_row_d;
      thr_col_q  <= thr_col_d;
      thr_row_q  <= thr_row_d;
      thr_data_q <= thr_data_d;
      wren_q     <= wren_d;
      fin_q      <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run) state_d = ST_READ;
      ST_READ:  if (tap_q == 4'd8) state_d = ST_LAST;
      ST_LAST:  state_d = ST_WRITE;
      ST_WRITE: state_d = last_pix ? ST_DONE : ST_READ;
      ST_DONE:  if (!run) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Tap k's address is registered on the edge entering it; its data is
  // accumulated one edge later, so the sum trails the address by one tap.
  always_comb begin
    tap_d      = tap_q;
    acc_d      = acc_q;
    col_d      = col_q;
    row_d      = row_q;
    thr_col_d  = thr_col_q;
    thr_row_d  = thr_row_q;
    thr_data_d = thr_data_q;
    wren_d     = 1'b0;
    load_addr  = 1'b0;
    addr_tap   = tap_q + 4'd1;
    addr_col   = col_q;
    addr_row   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          tap_d     = '0;
          acc_d     = '0;
          col_d     = '0;
          row_d     = '0;
          load_addr = 1'b1;
          addr_tap  = '0;
          addr_col  = '0;
          addr_row  = '0;
        end
      end
      ST_READ: begin
        if (tap_q != 4'd0) acc_d = acc_sum;
        if (tap_q != 4'd8) begin
          tap_d     = tap_q + 4'd1;
          load_addr = 1'b1;
        end
      end
      ST_LAST: begin
        acc_d      = acc_sum;
        wren_d     = 1'b1;
        thr_data_d = mean;
        thr_col_d  = col_q;
        thr_row_d  = row_q;
      end
      ST_WRITE: begin
        acc_d     = '0;
        tap_d     = '0;
        col_d     = nxt_col;
        row_d     = nxt_row;
        load_addr = !last_pix;
        addr_tap  = '0;
        addr_col  = nxt_col;
        addr_row  = nxt_row;
      end
      default: ;
    endcase
    fin_d = (state_d == ST_DONE);

    case (addr_tap)
      4'd0, 4'd1, 4'd2: dy_sel = 2'd0;
      4'd3, 4'd4, 4'd5: dy_sel = 2'd1;
      default:          dy_sel = 2'd2;
    endcase
    case (addr_tap)
      4'd0, 4'd3, 4'd6: dx_sel = 2'd0;
      4'd1, 4'd4, 4'd7: dx_sel = 2'd1;
      default:          dx_sel = 2'd2;
    endcase

    img_col_d = img_col_q;
    img_row_d = img_row_q;
    if (load_addr) begin
      case (dx_sel)
        2'd0:    img_col_d = (addr_col == '0) ? addr_col : addr_col - WIDTH_BITS'(1);
        2'd2:    img_col_d = (addr_col == '1) ? addr_col : addr_col + WIDTH_BITS'(1);
        default: img_col_d = addr_col;
      endcase
      case (dy_sel)
        2'd0:    img_row_d = (addr_row == '0) ? addr_row : addr_row - HEIGHT_BITS'(1);
        2'd2:    img_row_d = (addr_row == '1) ? addr_row : addr_row + HEIGHT_BITS'(1);
        default: img_row_d = addr_row;
      endcase
    end
  end

  assign oImageCol      = img_col_q;
  assign oImageRow      = img_row_q;
  assign oThresholdCol  = thr_col_q;
  assign oThresholdRow  = thr_row_q;
  assign oThresholdData = thr_data_q;
  assign oThresholdWren = wren_q;
  assign finished       = fin_q;

endmodule

// File: tb/tb_box_filter.sv
// Bench for box_filter on an 8x8 image: ROM model with 1-cycle latency,
// capture RAM, and a direct clamp-to-edge 3x3 mean reference.
module tb_box_filter;

  localparam int WB        = 3;
  localparam int HB        = 3;
  localparam int DIM       = 8;
  localparam int NPIX      = 64;
  localparam int FRAME_CYC = 704;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    global_state;
  logic [WB-1:0] oImageCol, oThresholdCol;
  logic [HB-1:0] oImageRow, oThresholdRow;
  logic [7:0]    iImageData, oThresholdData;
  logic          oThresholdWren, finished;

  logic [11:0]   div_acc;
  logic [7:0]    div_mean;

  logic [7:0]    img [0:DIM-1][0:DIM-1];
  logic [7:0]    cap [0:DIM-1][0:DIM-1];
  logic [5:0]    log_pix [0:1023];
  int            log_cyc [0:1023];
  int            wr_cnt = 0;
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;

  box_filter #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .RUN_STATE(3'd1)) dut (
    .clock          (clock),
    .reset          (reset),
    .global_state   (global_state),
    .oImageCol      (oImageCol),
    .oImageRow      (oImageRow),
    .iImageData     (iImageData),
    .oThresholdCol  (oThresholdCol),
    .oThresholdRow  (oThresholdRow),
    .oThresholdData (oThresholdData),
    .oThresholdWren (oThresholdWren),
    .finished       (finished)
  );

  box_mean_div9 u_div (.acc_i(div_acc), .mean_o(div_mean));

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc        <= cyc + 1;
    iImageData <= img[oImageRow][oImageCol];
    if (!reset && oThresholdWren && wr_cnt < 1024) begin
      cap[oThresholdRow][oThresholdCol] <= oThresholdData;
      log_pix[wr_cnt] <= {oThresholdRow, oThresholdCol};
      log_cyc[wr_cnt] <= cyc;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > DIM - 1) ? DIM - 1 : v);
  endfunction

  function automatic logic [7:0] ref_mean(input int r, input int c);
    int s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        s += int'(img[clampi(r + dy)][clampi(c + dx)]);
    return 8'(s / 9);
  endfunction

  task automatic set_image(input int kind);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        case (kind)
          0: img[r][c] = 8'd100;
          1: img[r][c] = 8'(c * 10);
          2: img[r][c] = (r == 0 && c == 0) ? 8'd255 : 8'd0;
          3: img[r][c] = 8'd255;
          default: img[r][c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic run_frame(input string name);
    int w0, c0, lat;
    bit seen, order_ok, gap_ok;
    w0   = wr_cnt;
    seen = 1'b0;
    lat  = 0;
    @(negedge clock);
    global_state = 3'd1;
    @(posedge clock);
    @(negedge clock);
    c0 = cyc;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clock);
      if (finished) begin
        seen = 1'b1;
        lat  = cyc - c0;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s finished_timeout: finished never rose within 2000 cycles", name);
      return;
    end
    checks++;
    if (lat !== FRAME_CYC) begin
      errors++;
      $display("FAIL %s finish_latency: got %0d cycles, expected %0d", name, lat, FRAME_CYC);
    end
    checks++;
    if (wr_cnt - w0 !== NPIX) begin
      errors++;
      $display("FAIL %s write_count: got %0d, expected %0d", name, wr_cnt - w0, NPIX);
    end else begin
      order_ok = 1'b1;
      gap_ok   = 1'b1;
      for (int i = 0; i < NPIX; i++) begin
        if (int'(log_pix[w0 + i]) != i) order_ok = 1'b0;
        if (i > 0 && log_cyc[w0 + i] - log_cyc[w0 + i - 1] != 11) gap_ok = 1'b0;
      end
      checks++;
      if (!order_ok) begin
        errors++;
        $display("FAIL %s raster_order: got %0b, expected 1", name, order_ok);
      end
      checks++;
      if (!gap_ok) begin
        errors++;
        $display("FAIL %s write_spacing: got %0b, expected 1 (11 cycles apart)", name, gap_ok);
      end
    end
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        checks++;
        if (cap[r][c] !== ref_mean(r, c)) begin
          errors++;
          $display("FAIL %s pixel(r%0d,c%0d): got %0d, expected %0d",
                   name, r, c, cap[r][c], ref_mean(r, c));
        end
      end
    repeat (3) @(negedge clock);
    checks++;
    if (finished !== 1'b1) begin
      errors++;
      $display("FAIL %s finished_hold: got %b, expected 1", name, finished);
    end
    global_state = 3'd0;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (finished !== 1'b0) begin
      errors++;
      $display("FAIL %s finished_fall: got %b, expected 0", name, finished);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({oImageCol, oImageRow, oThresholdCol, oThresholdRow} !== 12'd0) begin
      errors++;
      $display("FAIL %s addr_zero: got %h, expected 0", name,
               {oImageCol, oImageRow, oThresholdCol, oThresholdRow});
    end
    checks++;
    if (oThresholdData !== 8'd0) begin
      errors++;
      $display("FAIL %s data_zero: got %0d, expected 0", name, oThresholdData);
    end
    checks++;
    if ({oThresholdWren, finished} !== 2'b00) begin
      errors++;
      $display("FAIL %s ctrl_zero: got wren=%b finished=%b, expected 0 0", name,
               oThresholdWren, finished);
    end
  endtask

  task automatic test_reset();
    #1;
    check_outputs_zero("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_div9();
    for (int a = 0; a <= 2295; a++) begin
      div_acc = 12'(a);
      #1;
      checks++;
      if (div_mean !== 8'(a / 9)) begin
        errors++;
        $display("FAIL div9(%0d): got %0d, expected %0d", a, div_mean, a / 9);
      end
    end
  endtask

  task automatic test_state_gate();
    int w0;
    logic [WB+HB-1:0] addr0;
    bit fin_seen;
    w0       = wr_cnt;
    addr0    = {oImageRow, oImageCol};
    fin_seen = 1'b0;
    global_state = 3'd2;
    repeat (40) begin
      @(negedge clock);
      if (finished) fin_seen = 1'b1;
    end
    checks++;
    if ({oImageRow, oImageCol} !== addr0) begin
      errors++;
      $display("FAIL gate addr_hold: got %h, expected %h", {oImageRow, oImageCol}, addr0);
    end
    checks++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL gate no_writes: got %0d writes, expected 0", wr_cnt - w0);
    end
    checks++;
    if (fin_seen) begin
      errors++;
      $display("FAIL gate finished_low: got 1, expected 0");
    end
    global_state = 3'd0;
  endtask

  task automatic test_uniform();
    set_image(0);
    run_frame("uniform");
    checks++;
    if (cap[4][4] !== 8'd100) begin
      errors++;
      $display("FAIL uniform spot: got %0d, expected 100", cap[4][4]);
    end
  endtask

  task automatic test_ramp();
    set_image(1);
    run_frame("ramp");
    checks++;
    if ({cap[0][0], cap[3][7], cap[4][4]} !== {8'd3, 8'd66, 8'd40}) begin
      errors++;
      $display("FAIL ramp spots: got %0d %0d %0d, expected 3 66 40",
               cap[0][0], cap[3][7], cap[4][4]);
    end
  endtask

  task automatic test_single();
    set_image(2);
    run_frame("single");
    checks++;
    if ({cap[0][0], cap[0][1], cap[1][0], cap[1][1], cap[2][2]} !==
        {8'd113, 8'd56, 8'd56, 8'd28, 8'd0}) begin
      errors++;
      $display("FAIL single spots: got %0d %0d %0d %0d %0d, expected 113 56 56 28 0",
               cap[0][0], cap[0][1], cap[1][0], cap[1][1], cap[2][2]);
    end
  endtask

  task automatic test_all255();
    set_image(3);
    run_frame("all255");
    checks++;
    if ({cap[0][0], cap[7][7], cap[3][5]} !== {8'd255, 8'd255, 8'd255}) begin
      errors++;
      $display("FAIL all255 spots: got %0d %0d %0d, expected 255 255 255",
               cap[0][0], cap[7][7], cap[3][5]);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      set_image(4);
      run_frame("random");
    end
  endtask

  task automatic test_reset_midframe();
    set_image(4);
    @(negedge clock);
    global_state = 3'd1;
    repeat (300) @(negedge clock);
    reset        = 1'b1;
    global_state = 3'd0;
    #1;
    check_outputs_zero("midreset_now");
    repeat (2) @(negedge clock);
    check_outputs_zero("midreset_held");
    reset = 1'b0;
    set_image(4);
    run_frame("after_reset");
  endtask

  initial begin
    reset        = 1'b1;
    global_state = 3'd0;
    div_acc      = '0;
    set_image(0);
    repeat (3) @(negedge clock);
    test_reset();
    test_div9();
    test_state_gate();
    test_uniform();
    test_ramp();
    test_single();
    test_all255();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
